// File: rtl/cond_pkg.sv
// Shared definitions for the condition-evaluation pipeline.
//   - 4-bit condition code encodings COND_EQ .. COND_NV
//   - bit positions of the N, Z, C, V flags inside the status word
//   - flags_t: the 4-bit status word {N,Z,C,V}
package cond_pkg;

    typedef logic [3:0] flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_decode.sv
// Combinational evaluation of one condition code against a flag word.
// Ports:
//   cond  [3:0]  condition code (COND_EQ .. COND_NV)
//   flags        status word {N,Z,C,V}
//   pass         1 when the condition holds for the given flags
module cond_decode
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // pass unassigned, which would otherwise infer a latch.
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_eval_pipe.sv
// Registered multi-channel condition evaluator.
// Holds the NZCV status register, evaluates NUM_CH condition codes per cycle
// (channel 0 = oldest), registers pass/fail into the next stage with
// flush > stall > load priority, and keeps a saturating count of
// condition-failed instructions.
//
// Optional build macro COND_FLAG_FWD_EN: when defined, a flag write in the
// same cycle (flag_we=1, stall=0) is bypassed into the evaluation so a
// dependent conditional needs no bubble. When undefined, evaluation always
// uses the registered status and the hazard unit must insert a stall.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   stall      hold output stage and status register
//   flush      kill instructions in flight
//   flag_we    status register write enable
//   flag_in    new flags {N,Z,C,V}
//   in_valid   per-channel valid           [NUM_CH]
//   cond       per-channel condition code  [4*NUM_CH], ch i at [4i+3:4i]
//   cnt_clr    clear the failed-condition counter
//   out_valid  registered per-channel valid
//   cond_pass  registered per-channel pass, qualified by valid
//   status     current status register
//   fail_cnt   saturating failed-condition count
module cond_eval_pipe
    import cond_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                flag_we,
    input  flags_t              flag_in,
    input  logic [NUM_CH-1:0]   in_valid,
    input  logic [4*NUM_CH-1:0] cond,
    input  logic                cnt_clr,
    output logic [NUM_CH-1:0]   out_valid,
    output logic [NUM_CH-1:0]   cond_pass,
    output flags_t              status,
    output logic [CNT_W-1:0]    fail_cnt
);

    // Four bits hold a popcount of up to 8 channels.
    localparam int INC_W = 4;

    flags_t              eval_flags;
    logic [NUM_CH-1:0]   eval;
    logic [INC_W-1:0]    inc;
    logic [CNT_W+3:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_next;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef COND_FLAG_FWD_EN
    // The flag writer is older than every slot evaluated this cycle, so its
    // result is visible to them when the write actually commits.
    assign eval_flags = (flag_we && !stall) ? flag_in : status;
`else
    assign eval_flags = status;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cond_decode u_decode (
            .cond  (cond[4*i +: 4]),
            .flags (eval_flags),
            .pass  (eval[i])
        );
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            inc = inc + INC_W'(in_valid[i] & ~eval[i]);
        end
    end

    // Widened sum cannot wrap, so a simple compare saturates it.
    assign cnt_sum  = {4'b0, fail_cnt} + {{CNT_W{1'b0}}, inc};
    assign cnt_next = (cnt_sum > {4'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];

    // Status register: flush does not block the write because the writer is
    // older than the flushed slots; stall does.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            status <= '0;
        end else if (flag_we && !stall) begin
            status <= flag_in;
        end
    end

    // Output stage: flush > stall > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            cond_pass <= '0;
        end else if (flush) begin
            out_valid <= '0;
            cond_pass <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            cond_pass <= in_valid & eval;
        end
    end

    // Squashed-instruction counter; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt <= '0;
        end else if (cnt_clr) begin
            fail_cnt <= '0;
        end else if (!stall && !flush) begin
            fail_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_cond_eval_pipe.sv
// Directed self-checking bench for cond_eval_pipe (NUM_CH=4, CNT_W=4).
module tb_cond_eval_pipe;

    localparam int NCH = 4;
    localparam int CW  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic             flag_we;
    logic [3:0]       flag_in;
    logic [NCH-1:0]   in_valid;
    logic [4*NCH-1:0] cond;
    logic             cnt_clr;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   cond_pass;
    logic [3:0]       status;
    logic [CW-1:0]    fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cond_eval_pipe #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .in_valid  (in_valid),
        .cond      (cond),
        .cnt_clr   (cnt_clr),
        .out_valid (out_valid),
        .cond_pass (cond_pass),
        .status    (status),
        .fail_cnt  (fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: even codes are the base test, odd codes its inverse.
    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = ~(n ^ v);
            3'd6:    base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic load_flags(input logic [3:0] f);
        flag_we  = 1'b1;
        flag_in  = f;
        in_valid = '0;
        tick();
        flag_we  = 1'b0;
    endtask

    initial begin
        logic [15:0]    ch0_pass_f6;
        logic [NCH-1:0] exp_pass;
        logic [CW-1:0]  exp_cnt;

        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        flag_we  = 1'b1;
        flag_in  = 4'hF;
        in_valid = '1;
        cond     = 16'hEEEE;
        cnt_clr  = 1'b0;
        ch0_pass_f6 = '0;

        // Reset for two cycles while a flag write is requested.
        tick();
        tick();
        check("rst_status",    32'(status),    32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_cond_pass", 32'(cond_pass), 32'h0);
        check("rst_fail_cnt",  32'(fail_cnt),  32'h0);
        rst_n   = 1'b1;
        flag_we = 1'b0;

        // Full sweep: every flag value, every code on every channel.
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            check("sweep_status", 32'(status), 32'(f));
            for (int c = 0; c < 16; c++) begin
                cond     = {4'(c + 3), 4'(c + 2), 4'(c + 1), 4'(c)};
                in_valid = '1;
                for (int k = 0; k < NCH; k++) exp_pass[k] = ref_eval(4'(c + k), 4'(f));
                tick();
                check("sweep_pass",  32'(cond_pass), 32'(exp_pass));
                check("sweep_valid", 32'(out_valid), 32'hF);
                if (f == 6) ch0_pass_f6[c] = cond_pass[0];
            end
        end
        // Z=1,C=1: EQ CS PL VC LS GE LE AL pass.
        check("codes_z1c1", 32'(ch0_pass_f6), 32'h66A5);

        // Flag write ignored under stall, not blocked by flush.
        load_flags(4'h3);
        stall = 1'b1; flag_we = 1'b1; flag_in = 4'h9; in_valid = '0;
        tick();
        check("stall_blocks_we", 32'(status), 32'h3);
        stall = 1'b0; flush = 1'b1;
        tick();
        check("flush_allows_we", 32'(status), 32'h9);
        flush = 1'b0; flag_we = 1'b0;

        // Bypass: flag write and dependent EQ in the same cycle.
        load_flags(4'h0);
        flag_we = 1'b1; flag_in = 4'b0100; cond = 16'hFFF0; in_valid = 4'b0001;
        tick();
        flag_we = 1'b0;
`ifdef COND_FLAG_FWD_EN
        check("bypass_pass", 32'(cond_pass), 32'h1);
`else
        check("bypass_pass", 32'(cond_pass), 32'h0);
`endif
        check("bypass_status", 32'(status), 32'h4);

        // Stall / flush with status Z=1.
        cnt_clr = 1'b1; in_valid = '0;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(fail_cnt), 32'h0);
        cond = {4'hE, 4'hE, COND_NE_T(), 4'h0}; in_valid = 4'b0011;
        tick();
        check("load_valid", 32'(out_valid), 32'h3);
        check("load_pass",  32'(cond_pass), 32'h1);
        check("load_cnt",   32'(fail_cnt),  32'h1);
        stall = 1'b1; flag_we = 1'b1; flag_in = 4'h0; in_valid = '1; cond = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid",  32'(out_valid), 32'h3);
            check("stall_pass",   32'(cond_pass), 32'h1);
            check("stall_cnt",    32'(fail_cnt),  32'h1);
            check("stall_status", 32'(status),    32'h4);
        end
        flush = 1'b1;
        tick();
        check("sf_valid",  32'(out_valid), 32'h0);
        check("sf_pass",   32'(cond_pass), 32'h0);
        check("sf_cnt",    32'(fail_cnt),  32'h1);
        check("sf_status", 32'(status),    32'h4);
        stall = 1'b0; flag_in = 4'hB;
        tick();
        check("flush_valid",  32'(out_valid), 32'h0);
        check("flush_cnt",    32'(fail_cnt),  32'h1);
        check("flush_status", 32'(status),    32'hB);
        flush = 1'b0; flag_we = 1'b0;

        // Saturation: two NV failures per cycle, CNT_W=4.
        cnt_clr = 1'b1; in_valid = '0;
        tick();
        cnt_clr = 1'b0;
        cond = 16'hFFFF; in_valid = 4'b0011;
        exp_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            exp_cnt = (i == 7) ? 4'd15 : 4'(2 * (i + 1));
            tick();
            check("sat_cnt",   32'(fail_cnt),  32'(exp_cnt));
            check("sat_pass",  32'(cond_pass), 32'h0);
            check("sat_valid", 32'(out_valid), 32'h3);
        end
        in_valid = 4'b1111;
        tick();
        check("sat_hold", 32'(fail_cnt), 32'hF);
        cnt_clr = 1'b1;
        tick();
        check("clr_wins", 32'(fail_cnt), 32'h0);
        cnt_clr = 1'b0;

        // Multi-channel: N=1,V=0, conds {GE,LT,MI,NV}, valid 1011.
        load_flags(4'b1000);
        cond = 16'hAB4F; in_valid = 4'b1011;
        tick();
        check("mc_pass",  32'(cond_pass), 32'h2);
        check("mc_valid", 32'(out_valid), 32'hB);
        check("mc_cnt",   32'(fail_cnt),  32'h2);

        // Reset arriving mid-stall overrides everything.
        stall = 1'b1; rst_n = 1'b0; flag_we = 1'b1; flag_in = 4'hF;
        tick();
        check("rst_stall_status", 32'(status),    32'h0);
        check("rst_stall_valid",  32'(out_valid), 32'h0);
        check("rst_stall_pass",   32'(cond_pass), 32'h0);
        check("rst_stall_cnt",    32'(fail_cnt),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [3:0] COND_NE_T();
        return 4'b0001;
    endfunction

endmodule

// File: doc/cond_eval_pipe.md
Name: cond_eval_pipe

Overview:
- Parametrised, registered successor to the single-channel condition checker.
- Holds the architectural NZCV status register and evaluates NUM_CH condition codes per cycle, one per issue slot, against that register.
- Registers the pass/fail results into the next pipeline stage, honouring stall and flush.
- Keeps a saturating count of condition-failed (squashed) instructions for performance monitoring.

Parameters:
- NUM_CH, 2, number of parallel condition-evaluation channels (1..8); channel 0 is the oldest instruction.
- CNT_W, 16, width of the failed-condition counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold the output stage and the status register.
- flush  in  1  kill the instructions in flight.
- flag_we  in  1  write enable for the status register (ALU with S bit set).
- flag_in  in  4  new flags {N,Z,C,V}.
- in_valid  in  NUM_CH  per-channel valid instruction.
- cond  in  4*NUM_CH  per-channel condition code; channel i is bits [4i+3:4i].
- cnt_clr  in  1  clear the failed-condition counter.
- out_valid  out  NUM_CH  registered per-channel valid.
- cond_pass  out  NUM_CH  registered per-channel condition passed (qualified by valid).
- status  out  4  current status register {N,Z,C,V}.
- fail_cnt  out  CNT_W  saturating count of condition-failed instructions.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - status=0, out_valid=0, cond_pass=0, fail_cnt=0.
  - Reset overrides every other input, including when it arrives mid-stall.
- Status register:
  - Loads flag_in when flag_we=1 and stall=0.
  - flag_we is ignored while stall=1.
  - flush does not block a flag write, because the writer is older than the flushed slots.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL always 1; 1111 NV always 0.
- Flag source: selected by the optional feature below.
- Output stage (latency 1 cycle):
  - Priority is flush > stall > load.
  - flush=1: out_valid=0 and cond_pass=0 at the next edge, regardless of stall.
  - Else stall=1: out_valid and cond_pass hold.
  - Else: out_valid[i]=in_valid[i] and cond_pass[i]=in_valid[i]&eval[i].
  - cond_pass is never 1 while out_valid is 0.
- Fail counter:
  - inc = popcount over i of (in_valid[i] & !eval[i]), counted only in cycles with stall=0 and flush=0.
  - fail_cnt = min(fail_cnt+inc, 2^CNT_W-1); the sum is computed CNT_W+4 bits wide before saturation, so there is no wrap.
  - cnt_clr=1 sets fail_cnt=0 and has priority over a same-cycle increment.
- Simultaneous events:
  - flag_we together with in_valid in the same cycle: resolved by the feature.
  - stall+flush: flush wins at the output stage, and the status register is still stalled.

Optional Feature:
- Macro: COND_FLAG_FWD_EN.
- Defined:
  - eval uses flag_in when flag_we=1 and stall=0, otherwise status.
  - This is a same-cycle bypass, so a dependent conditional instruction needs no bubble.
- Undefined:
  - eval always uses the registered status.
  - The hazard unit must insert one stall between a flag writer and a dependent conditional.
  - The bypass mux is absent.

Decomposition:
- Package cond_pkg:
  - Localparams COND_EQ..COND_NV (4-bit).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flags_t (4-bit).
- Sub-module cond_decode:
  - Purely combinational: inputs cond[3:0] and flags_t, output pass.
  - Instantiated NUM_CH times in a generate loop.
- The status register, output stage and counter live in cond_eval_pipe.

Test Plan:
- Reset: set rst_n=0 for 2 cycles with flag_we=1 and flag_in=4'hF → status=0, out_valid=0, fail_cnt=0.
- Full code sweep: preload status=4'b0110 (Z=1,C=1), drive all 16 codes on ch0 → next-cycle cond_pass=1 for EQ, CS, PL, VC, LS, GE, LE, AL and 0 for the rest; repeat over all 16 flag values against a reference model.
- Bypass: cycle N drives flag_we=1, flag_in=Z set, ch0 cond=EQ, in_valid=1 → with COND_FLAG_FWD_EN cond_pass[0]=1 at N+1; without it cond_pass[0]=0.
- Stall/flush: load out_valid=2'b11, then stall=1 for 3 cycles with new inputs → outputs hold and fail_cnt is unchanged; then stall=1 with flush=1 → out_valid=0 next cycle.
- Counter saturation (CNT_W=4): NUM_CH=2, both channels cond=NV valid for 8 cycles → fail_cnt counts 2,4,…,14,15 and holds at 15; cnt_clr=1 in the same cycle as an increment → 0.
- Multi-channel: NUM_CH=4, status N=1,V=0, conds {GE,LT,MI,NV}, in_valid=4'b1011 → cond_pass=4'b0010, out_valid=4'b1011, fail_cnt+=2.
